// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter / fetch slice.
package pc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10,
        TRAP  = 2'b11
    } pc_state_t;

    // Encoding 2'b11 is reserved and decoded as RM_PCREL by the target calculator.
    typedef enum logic [1:0] {
        RM_ABS    = 2'b00,
        RM_PCREL  = 2'b01,
        RM_REGREL = 2'b10
    } redir_mode_t;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int unsigned DEF_INC      = 32'd4;
    localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect-target calculator with alignment check.
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned ALIGN_BITS = 2
) (
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] data,
    input  logic [ADDR_W-1:0] imm,
    output logic [ADDR_W-1:0] target,
    output logic              misaligned
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~({ADDR_W{1'b1}} << ALIGN_BITS);
    localparam logic [ADDR_W-1:0] BIT0_CLR   = {{(ADDR_W-1){1'b1}}, 1'b0};

    // Target select; bit0 of the JALR form is dropped before the alignment test.
    always_comb begin
        target = pc + imm;
        case (redir_mode_t'(mode))
            RM_ABS:    target = data;
            RM_PCREL:  target = pc + imm;
            RM_REGREL: target = (data + imm) & BIT0_CLR;
            default:   target = pc + imm;
        endcase
        misaligned = |(target & ALIGN_MASK);
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// RV32I program counter with fetch request/ack handshake, one pending redirect
// slot and a sticky misaligned-target trap.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int unsigned        ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC   = ADDR_W'(DEF_RESET_PC),
    parameter int unsigned        INC        = DEF_INC,
    parameter int unsigned        ALIGN_BITS = 2,
    parameter logic [ADDR_W-1:0]  TRAP_VEC   = ADDR_W'(DEF_TRAP_VEC)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              stall,
    input  logic              redirect_en,
    input  logic [1:0]        redirect_mode,
    input  logic [ADDR_W-1:0] data,
    input  logic [ADDR_W-1:0] immediate_value,
    input  logic              trap_clear,
    output logic              fetch_req,
    output logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_ack,
    output logic              fetch_kill,
    output logic [ADDR_W-1:0] pc_val,
    output logic [ADDR_W-1:0] pc_next_seq,
    output logic              misalign_trap
);

    pc_state_t         state_r, state_nxt_s;
    logic [ADDR_W-1:0] pc_r, pc_nxt_s;
    logic              pend_valid_r, pend_valid_nxt_s;
    logic [ADDR_W-1:0] pend_target_r, pend_target_nxt_s;
    logic              pend_mis_r, pend_mis_nxt_s;
    logic              trap_r, trap_nxt_s;

    logic [ADDR_W-1:0] calc_target_s;
    logic              calc_mis_s;
    logic [ADDR_W-1:0] pc_seq_s;
    logic              load_en_s, load_mis_s, seq_en_s;
    logic [ADDR_W-1:0] load_target_s;

    assign pc_seq_s = pc_r + ADDR_W'(INC);

    pc_target_calc #(
        .ADDR_W     (ADDR_W),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_target_calc (
        .mode       (redirect_mode),
        .pc         (pc_r),
        .data       (data),
        .imm        (immediate_value),
        .target     (calc_target_s),
        .misaligned (calc_mis_s)
    );

    // State and datapath registers; clr aborts everything, including a live request.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r       <= IDLE;
            pc_r          <= RESET_PC;
            pend_valid_r  <= 1'b0;
            pend_target_r <= {ADDR_W{1'b0}};
            pend_mis_r    <= 1'b0;
            trap_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            pc_r          <= pc_nxt_s;
            pend_valid_r  <= pend_valid_nxt_s;
            pend_target_r <= pend_target_nxt_s;
            pend_mis_r    <= pend_mis_nxt_s;
            trap_r        <= trap_nxt_s;
        end
    end

    // Next-state logic: live redirect beats pending beats sequential on a PC load.
    always_comb begin
        state_nxt_s       = state_r;
        pend_valid_nxt_s  = pend_valid_r;
        pend_target_nxt_s = pend_target_r;
        pend_mis_nxt_s    = pend_mis_r;
        trap_nxt_s        = trap_r;
        load_en_s         = 1'b0;
        load_mis_s        = 1'b0;
        load_target_s     = pc_r;
        seq_en_s          = 1'b0;

        case (state_r)
            IDLE: begin
                if (!stall) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH: begin
                if (fetch_ack) begin
                    pend_valid_nxt_s = 1'b0;
                    state_nxt_s      = stall ? HOLD : FETCH;
                    if (redirect_en) begin
                        load_en_s     = 1'b1;
                        load_target_s = calc_target_s;
                        load_mis_s    = calc_mis_s;
                    end else if (pend_valid_r) begin
                        load_en_s     = 1'b1;
                        load_target_s = pend_target_r;
                        load_mis_s    = pend_mis_r;
                    end else begin
                        seq_en_s = 1'b1;
                    end
                end else if (redirect_en) begin
                    pend_valid_nxt_s  = 1'b1;
                    pend_target_nxt_s = calc_target_s;
                    pend_mis_nxt_s    = calc_mis_s;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            HOLD: begin
                pend_valid_nxt_s = 1'b0;
                state_nxt_s      = stall ? HOLD : FETCH;
                if (redirect_en) begin
                    load_en_s     = 1'b1;
                    load_target_s = calc_target_s;
                    load_mis_s    = calc_mis_s;
                end else if (pend_valid_r) begin
                    load_en_s     = 1'b1;
                    load_target_s = pend_target_r;
                    load_mis_s    = pend_mis_r;
                end else begin
                    load_en_s = 1'b0;
                end
            end
            TRAP: begin
                if (trap_clear) begin
                    trap_nxt_s  = 1'b0;
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = TRAP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        if (load_en_s && load_mis_s) begin
            pc_nxt_s         = TRAP_VEC;
            trap_nxt_s       = 1'b1;
            state_nxt_s      = TRAP;
            pend_valid_nxt_s = 1'b0;
        end else if (load_en_s) begin
            pc_nxt_s = load_target_s;
        end else if (seq_en_s) begin
            pc_nxt_s = pc_seq_s;
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // Output decode straight from registered state; kill depends only on pend_valid.
    always_comb begin
        fetch_req     = (state_r == FETCH);
        fetch_kill    = (state_r == FETCH) && pend_valid_r;
        fetch_addr    = pc_r;
        pc_val        = pc_r;
        pc_next_seq   = pc_seq_s;
        misalign_trap = trap_r;
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with hand-computed expected values.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic        stall;
    logic        redirect_en;
    logic [1:0]  redirect_mode;
    logic [31:0] data;
    logic [31:0] immediate_value;
    logic        trap_clear;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic        fetch_kill;
    logic [31:0] pc_val;
    logic [31:0] pc_next_seq;
    logic        misalign_trap;

    int pass_cnt  = 0;
    int check_cnt = 0;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk             (clk),
        .clr             (clr),
        .stall           (stall),
        .redirect_en     (redirect_en),
        .redirect_mode   (redirect_mode),
        .data            (data),
        .immediate_value (immediate_value),
        .trap_clear      (trap_clear),
        .fetch_req       (fetch_req),
        .fetch_addr      (fetch_addr),
        .fetch_ack       (fetch_ack),
        .fetch_kill      (fetch_kill),
        .pc_val          (pc_val),
        .pc_next_seq     (pc_next_seq),
        .misalign_trap   (misalign_trap)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [1:0] m, input logic [31:0] d, input logic [31:0] i);
        redirect_en     = 1'b1;
        redirect_mode   = m;
        data            = d;
        immediate_value = i;
    endtask

    initial begin
        clr = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_mode = 2'b00;
        data = 32'h0; immediate_value = 32'h0; trap_clear = 1'b0; fetch_ack = 1'b0;
        #1;
        check("rst_pc", pc_val, 32'h0);
        check("rst_req", {31'h0, fetch_req}, 32'h0);
        check("rst_kill", {31'h0, fetch_kill}, 32'h0);
        check("rst_trap", {31'h0, misalign_trap}, 32'h0);

        tick(); tick();
        clr = 1'b1; fetch_ack = 1'b1;
        tick();
        check("idle_to_fetch_req", {31'h0, fetch_req}, 32'h1);
        check("seq_addr0", fetch_addr, 32'h0);
        tick();
        check("seq_addr4", fetch_addr, 32'h4);
        check("seq_kill", {31'h0, fetch_kill}, 32'h0);
        tick();
        check("seq_addr8", fetch_addr, 32'h8);
        tick();
        check("seq_pc12", pc_val, 32'hC);

        fetch_ack = 1'b0; stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("wait_req", {31'h0, fetch_req}, 32'h1);
            check("wait_addr", fetch_addr, 32'hC);
        end
        fetch_ack = 1'b1;
        tick();
        check("hold_req", {31'h0, fetch_req}, 32'h0);
        check("hold_pc16", pc_val, 32'h10);

        fetch_ack = 1'b0; stall = 1'b0;
        tick();
        check("hold_exit_req", {31'h0, fetch_req}, 32'h1);
        redir(2'b01, 32'h0, 32'h20);
        tick();
        check("pend_pc_unchanged", pc_val, 32'h10);
        check("pend_kill", {31'h0, fetch_kill}, 32'h1);
        redirect_en = 1'b0; fetch_ack = 1'b1;
        tick();
        check("pend_applied", fetch_addr, 32'h30);
        check("kill_cleared", {31'h0, fetch_kill}, 32'h0);
        check("next_seq", pc_next_seq, 32'h34);

        redir(2'b10, 32'h1001, 32'h0);
        tick();
        check("jalr_bit0", pc_val, 32'h1000);
        check("jalr_no_trap", {31'h0, misalign_trap}, 32'h0);
        redir(2'b00, 32'h1002, 32'h0);
        tick();
        check("mis_trap", {31'h0, misalign_trap}, 32'h1);
        check("mis_pc", pc_val, 32'h100);
        check("mis_req", {31'h0, fetch_req}, 32'h0);
        redir(2'b00, 32'h2000, 32'h0);
        tick();
        check("trap_ignores_redir", pc_val, 32'h100);
        redirect_en = 1'b0; trap_clear = 1'b1;
        tick();
        trap_clear = 1'b0;
        check("trap_clr_flag", {31'h0, misalign_trap}, 32'h0);
        check("trap_clr_addr", fetch_addr, 32'h100);
        check("trap_clr_req", {31'h0, fetch_req}, 32'h1);

        redir(2'b00, 32'hFFFF_FFFC, 32'h0);
        tick();
        check("pc_top", pc_val, 32'hFFFF_FFFC);
        check("next_seq_wrap", pc_next_seq, 32'h0);
        redirect_en = 1'b0;
        tick();
        check("wrap_pc", pc_val, 32'h0);
        check("wrap_no_trap", {31'h0, misalign_trap}, 32'h0);

        redir(2'b11, 32'h0, 32'h8);
        tick();
        check("mode11_pcrel", pc_val, 32'h8);

        fetch_ack = 1'b0;
        redir(2'b01, 32'h0, 32'h2);
        tick();
        check("mis_pend_no_trap_yet", {31'h0, misalign_trap}, 32'h0);
        redirect_en = 1'b0; fetch_ack = 1'b1;
        tick();
        check("mis_pend_trap", {31'h0, misalign_trap}, 32'h1);
        check("mis_pend_pc", pc_val, 32'h100);
        trap_clear = 1'b1;
        tick();
        trap_clear = 1'b0;

        fetch_ack = 1'b0;
        redir(2'b00, 32'h200, 32'h0);
        tick();
        check("pre_clr_kill", {31'h0, fetch_kill}, 32'h1);
        check("pre_clr_pc", pc_val, 32'h100);
        #2;
        clr = 1'b0;
        #1;
        check("async_pc", pc_val, 32'h0);
        check("async_req", {31'h0, fetch_req}, 32'h0);
        check("async_kill", {31'h0, fetch_kill}, 32'h0);
        check("async_trap", {31'h0, misalign_trap}, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
